// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin issue controller for NUM_WARPS warp contexts.
// Each warp holds a PC and a 2-bit state (DONE/READY/MEM_WAIT/ACTIVE). One warp
// at a time walks SELECT -> FETCH -> EXEC -> UPDATE, while warps parked in
// MEM_WAIT are released by mem_done in parallel.
// Optional feature macro: WARP_SCHED_PERF_EN adds perf_issued/perf_stall counters.
module warp_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int PC_BITS   = 8,
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WID_BITS:0]      warp_count,
  output logic                   fetch_valid,
  output logic [WID_BITS-1:0]    fetch_warp,
  output logic [PC_BITS-1:0]     fetch_pc,
  input  logic                   fetch_ready,
  input  logic                   decoded_ret,
  input  logic                   decoded_mem,
  input  logic                   decoded_jump,
  input  logic [PC_BITS-1:0]     jump_target,
  output logic                   exec_valid,
  input  logic                   mem_done,
  input  logic [WID_BITS-1:0]    mem_done_warp,
  output logic [2*NUM_WARPS-1:0] warp_state,
  output logic                   done,
  output logic                   error
`ifdef WARP_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] W_DONE     = 2'd0;
  localparam logic [1:0] W_READY    = 2'd1;
  localparam logic [1:0] W_MEM_WAIT = 2'd2;
  localparam logic [1:0] W_ACTIVE   = 2'd3;

  state_t              state_q, state_d;
  logic [1:0]          wst_q [NUM_WARPS];
  logic [PC_BITS-1:0]  pc_q  [NUM_WARPS];
  logic [WID_BITS-1:0] rr_q;
  logic                error_q;

  // decoded instruction captured in EXEC, applied in UPDATE
  logic                dec_ret_p0, dec_mem_p0, dec_jump_p0;
  logic [PC_BITS-1:0]  dec_tgt_p0;

  logic                any_ready, all_done, sel_found;
  logic [WID_BITS-1:0] sel_idx;
  logic                start_ok;
  int                  live_cnt;

  // round-robin scan for the first READY warp after the last issued one
  always_comb begin
    int j;
    any_ready = 1'b0;
    all_done  = 1'b1;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (wst_q[i] != W_DONE)  all_done  = 1'b0;
      if (wst_q[i] == W_READY) any_ready = 1'b1;
    end
    for (int i = 1; i <= NUM_WARPS; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_WARPS) j = j - NUM_WARPS;
      if (!sel_found && wst_q[j] == W_READY) begin
        sel_found = 1'b1;
        sel_idx   = WID_BITS'(j);
      end
    end
  end

  // start acceptance and live-warp count clamped to the number of contexts
  always_comb begin
    start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    live_cnt = (int'(warp_count) > NUM_WARPS) ? NUM_WARPS : int'(warp_count);
  end

  // issue FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // issue FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (live_cnt == 0) ? S_DONE : S_SELECT;
      S_SELECT: begin
        if (sel_found)     state_d = S_FETCH;
        else if (all_done) state_d = S_DONE;
      end
      S_FETCH:  if (fetch_ready) state_d = S_EXEC;
      S_EXEC:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_SELECT;
      default:  state_d = S_IDLE;
    endcase
  end

  // issue FSM outputs, decoded purely from registered state
  always_comb begin
    fetch_valid = (state_q == S_FETCH);
    exec_valid  = (state_q == S_EXEC);
    done        = (state_q == S_DONE);
  end

  // warp contexts: start init, selection, UPDATE writeback, memory completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        wst_q[i] <= W_DONE;
        pc_q[i]  <= '0;
      end
      rr_q        <= WID_BITS'(NUM_WARPS - 1);
      error_q     <= 1'b0;
      dec_ret_p0  <= 1'b0;
      dec_mem_p0  <= 1'b0;
      dec_jump_p0 <= 1'b0;
      dec_tgt_p0  <= '0;
    end else begin
      if (mem_done) begin
        if (int'(mem_done_warp) >= NUM_WARPS)        error_q <= 1'b1;
        else if (wst_q[mem_done_warp] == W_MEM_WAIT) wst_q[mem_done_warp] <= W_READY;
        else                                         error_q <= 1'b1;
      end
      case (state_q)
        S_SELECT: begin
          if (sel_found) begin
            wst_q[sel_idx] <= W_ACTIVE;
            rr_q           <= sel_idx;
          end
        end
        // ---- stage boundary: EXEC captures decode ----
        S_EXEC: begin
          dec_ret_p0  <= decoded_ret;
          dec_mem_p0  <= decoded_mem;
          dec_jump_p0 <= decoded_jump;
          dec_tgt_p0  <= jump_target;
        end
        // ---- stage boundary: UPDATE retires into the warp context ----
        S_UPDATE: begin
          if (dec_ret_p0) begin
            wst_q[rr_q] <= W_DONE;
          end else if (dec_mem_p0) begin
            wst_q[rr_q] <= W_MEM_WAIT;
            pc_q[rr_q]  <= pc_q[rr_q] + PC_BITS'(1);
          end else if (dec_jump_p0) begin
            wst_q[rr_q] <= W_READY;
            pc_q[rr_q]  <= dec_tgt_p0;
          end else begin
            wst_q[rr_q] <= W_READY;
            pc_q[rr_q]  <= pc_q[rr_q] + PC_BITS'(1);
          end
        end
        default: ;
      endcase
      if (start_ok) begin
        for (int i = 0; i < NUM_WARPS; i++) begin
          wst_q[i] <= (i < live_cnt) ? W_READY : W_DONE;
          pc_q[i]  <= '0;
        end
        error_q <= 1'b0;
      end
    end
  end

  // packed state view and fetch address of the current warp
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) warp_state[2*i +: 2] = wst_q[i];
    fetch_warp = rr_q;
    fetch_pc   = pc_q[rr_q];
    error      = error_q;
  end

`ifdef WARP_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // issue and stall counters, saturating, cleared on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (start_ok) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (state_q == S_EXEC) perf_issued <= sat_inc(perf_issued);
      if (state_q == S_SELECT && !any_ready && !all_done) perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed testbench for warp_scheduler (NUM_WARPS=4, PC_BITS=8).
// A small responder turns fetch_warp/fetch_pc into decoded_* per scenario.
module tb_warp_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] warp_count;
  logic       fetch_valid;
  logic [1:0] fetch_warp;
  logic [7:0] fetch_pc;
  logic       fetch_ready;
  logic       decoded_ret, decoded_mem, decoded_jump;
  logic [7:0] jump_target;
  logic       exec_valid;
  logic       mem_done;
  logic [1:0] mem_done_warp;
  logic [7:0] warp_state;
  logic       done;
  logic       error;
`ifdef WARP_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;

  warp_scheduler #(.NUM_WARPS(4), .PC_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .warp_count(warp_count),
    .fetch_valid(fetch_valid), .fetch_warp(fetch_warp), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .decoded_ret(decoded_ret), .decoded_mem(decoded_mem),
    .decoded_jump(decoded_jump), .jump_target(jump_target), .exec_valid(exec_valid),
    .mem_done(mem_done), .mem_done_warp(mem_done_warp), .warp_state(warp_state),
    .done(done), .error(error)
`ifdef WARP_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // per-scenario program: 3 = w0 pc0 is LDR, 4 = all LDR, 5 = jumps, 6 = all RET
  always_comb begin
    decoded_ret  = (mode == 6);
    decoded_mem  = (mode == 4) || (mode == 3 && fetch_warp == 2'd0 && fetch_pc == 8'h00);
    decoded_jump = (mode == 5) && ((fetch_pc == 8'h00) || (fetch_warp == 2'd0 && fetch_pc == 8'hFF));
    jump_target  = (fetch_pc == 8'h00) ? 8'hFF : 8'h10;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; warp_count = 3'd0; fetch_ready = 1'b0;
    mem_done = 1'b0; mem_done_warp = 2'd0; mode = 0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic do_start(input logic [2:0] cnt);
    warp_count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got=%0b exp=0", fetch_valid); else n_pass++;
    n_checks++; if (exec_valid !== 1'b0) $display("FAIL rst_exec_valid got=%0b exp=0", exec_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got=%0b exp=0", done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL rst_error got=%0b exp=0", error); else n_pass++;
    n_checks++; if (warp_state !== 8'h00) $display("FAIL rst_warp_state got=%h exp=00", warp_state); else n_pass++;
    n_checks++; if (fetch_warp !== 2'd3) $display("FAIL rst_rr_ptr got=%0d exp=3", fetch_warp); else n_pass++;
    n_checks++; if (fetch_pc !== 8'h00) $display("FAIL rst_fetch_pc got=%h exp=00", fetch_pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start(3'd2);
    tick();
    n_checks++; if (fetch_valid !== 1'b1) $display("FAIL arst_pre_fetch got=%0b exp=1", fetch_valid); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL arst_fetch_valid got=%0b exp=0", fetch_valid); else n_pass++;
    n_checks++; if (warp_state !== 8'h00) $display("FAIL arst_warp_state got=%h exp=00", warp_state); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL arst_done got=%0b exp=0", done); else n_pass++;
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [1:0] fw [4];
    logic [7:0] fp [4];
    int nf, nexec, first_exec, last_exec;
    logic gap_ok;
    do_reset();
    fetch_ready = 1'b1;
    do_start(3'd2);
    nf = 0; nexec = 0; first_exec = -1; last_exec = -1; gap_ok = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (fetch_valid && nf < 4) begin fw[nf] = fetch_warp; fp[nf] = fetch_pc; nf++; end
      if (exec_valid) begin
        if (first_exec < 0) first_exec = cyc;
        if (last_exec >= 0 && cyc - last_exec != 4) gap_ok = 1'b0;
        last_exec = cyc; nexec++;
      end
      if (cyc == 20) begin start = 1'b1; warp_count = 3'd1; end
      if (cyc == 21) begin
        start = 1'b0;
        n_checks++; if (warp_state[3:2] !== 2'd3) $display("FAIL busy_start_ignored got=%0d exp=3", warp_state[3:2]); else n_pass++;
      end
      tick();
    end
    n_checks++; if (nf !== 4) $display("FAIL rr_fetch_count got=%0d exp=4", nf); else n_pass++;
    if (nf == 4) begin
      n_checks++; if ({fw[0], fw[1], fw[2], fw[3]} !== {2'd0, 2'd1, 2'd0, 2'd1})
        $display("FAIL rr_warp_seq got=%0d,%0d,%0d,%0d exp=0,1,0,1", fw[0], fw[1], fw[2], fw[3]); else n_pass++;
      n_checks++; if ({fp[0], fp[1], fp[2], fp[3]} !== {8'd0, 8'd0, 8'd1, 8'd1})
        $display("FAIL rr_pc_seq got=%0d,%0d,%0d,%0d exp=0,0,1,1", fp[0], fp[1], fp[2], fp[3]); else n_pass++;
    end
    n_checks++; if (first_exec !== 2) $display("FAIL rr_first_exec got=%0d exp=2", first_exec); else n_pass++;
    n_checks++; if (gap_ok !== 1'b1 || nexec !== 10) $display("FAIL rr_exec_interval got=n%0d gapok%0b exp=n10 gapok1", nexec, gap_ok); else n_pass++;
`ifdef WARP_SCHED_PERF_EN
    n_checks++; if (perf_issued !== 32'd10) $display("FAIL perf_issued got=%0d exp=10", perf_issued); else n_pass++;
`endif
  endtask

  task automatic test_latency_hiding();
    logic found;
    int ex1;
    do_reset();
    mode = 3; fetch_ready = 1'b1;
    do_start(3'd2);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (warp_state[1:0] == 2'd2) found = 1'b1; else tick();
    end
    n_checks++; if (found !== 1'b1) $display("FAIL lh_w0_memwait got=timeout exp=state2"); else n_pass++;
    ex1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (exec_valid && fetch_warp == 2'd1) ex1++;
      if (k == 10) begin
        n_checks++; if (warp_state[1:0] !== 2'd2) $display("FAIL lh_w0_parked got=%0d exp=2", warp_state[1:0]); else n_pass++;
      end
      tick();
    end
    n_checks++; if (ex1 !== 5) $display("FAIL lh_w1_issues got=%0d exp=5", ex1); else n_pass++;
    mem_done = 1'b1; mem_done_warp = 2'd0;
    tick();
    mem_done = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (fetch_valid && fetch_warp == 2'd0) found = 1'b1; else tick();
    end
    n_checks++; if (!found || fetch_pc !== 8'h01) $display("FAIL lh_w0_resume_pc got=%h found=%0b exp=01", fetch_pc, found); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL lh_error got=%0b exp=0", error); else n_pass++;
  endtask

  task automatic test_all_mem_wait();
    logic found, quiet;
`ifdef WARP_SCHED_PERF_EN
    logic [31:0] s0;
`endif
    do_reset();
    mode = 4; fetch_ready = 1'b1;
    do_start(3'd2);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (warp_state[3:0] == 4'b1010) found = 1'b1; else tick();
    end
    n_checks++; if (found !== 1'b1) $display("FAIL mw_both_wait got=timeout exp=1010"); else n_pass++;
`ifdef WARP_SCHED_PERF_EN
    s0 = perf_stall;
`endif
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (fetch_valid || exec_valid) quiet = 1'b0;
      tick();
    end
    n_checks++; if (quiet !== 1'b1) $display("FAIL mw_no_fetch got=activity exp=idle"); else n_pass++;
`ifdef WARP_SCHED_PERF_EN
    n_checks++; if (perf_stall !== s0 + 32'd8) $display("FAIL perf_stall got=%0d exp=%0d", perf_stall, s0 + 32'd8); else n_pass++;
`endif
    mem_done = 1'b1; mem_done_warp = 2'd1;
    tick();
    mem_done = 1'b0;
    n_checks++; if (warp_state[3:0] !== 4'b0110) $display("FAIL mw_w1_ready got=%b exp=0110", warp_state[3:0]); else n_pass++;
    tick();
    n_checks++; if (fetch_valid !== 1'b1 || fetch_warp !== 2'd1 || fetch_pc !== 8'h01)
      $display("FAIL mw_w1_resume got=v%0b w%0d pc%h exp=v1 w1 pc01", fetch_valid, fetch_warp, fetch_pc); else n_pass++;
  endtask

  task automatic test_jump_wrap();
    logic [1:0] fw [6];
    logic [7:0] fp [6];
    int nf;
    do_reset();
    mode = 5; fetch_ready = 1'b1;
    do_start(3'd2);
    nf = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (fetch_valid && nf < 6) begin fw[nf] = fetch_warp; fp[nf] = fetch_pc; nf++; end
      tick();
    end
    n_checks++; if (nf !== 6) $display("FAIL jw_fetch_count got=%0d exp=6", nf); else n_pass++;
    if (nf == 6) begin
      n_checks++; if ({fw[2], fp[2], fw[3], fp[3]} !== {2'd0, 8'hFF, 2'd1, 8'hFF})
        $display("FAIL jw_jump_to_ff got=w%0d %h w%0d %h exp=w0 ff w1 ff", fw[2], fp[2], fw[3], fp[3]); else n_pass++;
      n_checks++; if ({fw[4], fp[4]} !== {2'd0, 8'h10}) $display("FAIL jw_jump_path got=w%0d %h exp=w0 10", fw[4], fp[4]); else n_pass++;
      n_checks++; if ({fw[5], fp[5]} !== {2'd1, 8'h00}) $display("FAIL jw_pc_wrap got=w%0d %h exp=w1 00", fw[5], fp[5]); else n_pass++;
    end
  endtask

  task automatic test_ret_done_error();
    logic found;
    do_reset();
    mode = 6; fetch_ready = 1'b1;
    do_start(3'd2);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (warp_state == 8'h00) found = 1'b1; else tick();
    end
    n_checks++; if (found !== 1'b1 || done !== 1'b0) $display("FAIL rd_after_update got=found%0b done%0b exp=found1 done0", found, done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL rd_done got=%0b exp=1", done); else n_pass++;
    mem_done = 1'b1; mem_done_warp = 2'd0;
    tick();
    mem_done = 1'b0;
    n_checks++; if (error !== 1'b1) $display("FAIL rd_error_set got=%0b exp=1", error); else n_pass++;
    n_checks++; if (warp_state !== 8'h00 || done !== 1'b1) $display("FAIL rd_state_kept got=%h done%0b exp=00 done1", warp_state, done); else n_pass++;
    mode = 0;
    do_start(3'd1);
    n_checks++; if (error !== 1'b0 || done !== 1'b0) $display("FAIL rd_restart_clear got=err%0b done%0b exp=0 0", error, done); else n_pass++;
    n_checks++; if (warp_state !== 8'h01) $display("FAIL rd_restart_state got=%h exp=01", warp_state); else n_pass++;
  endtask

  task automatic test_count_bounds();
    do_reset();
    do_start(3'd0);
    n_checks++; if (done !== 1'b1 || warp_state !== 8'h00) $display("FAIL cb_zero got=done%0b st%h exp=done1 st00", done, warp_state); else n_pass++;
    do_start(3'd7);
    n_checks++; if (warp_state !== 8'h55 || done !== 1'b0) $display("FAIL cb_clamp got=st%h done%0b exp=st55 done0", warp_state, done); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; warp_count = 3'd0; fetch_ready = 1'b0;
    mem_done = 1'b0; mem_done_warp = 2'd0;
    test_reset();
    test_async_reset();
    test_round_robin();
    test_latency_hiding();
    test_all_mem_wait();
    test_jump_wrap();
    test_ret_done_error();
    test_count_bounds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
